mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached downstream of the single-cycle RISC-V core's data bus. Writes to a TXDATA register are queued in a small FIFO. A baud-rate FSM serialises each byte as 8N1 on `tx`. The core has no stall path, so this block accepts every access in the cycle it is issued and returns read data combinationally in the same cycle.

---
 rtl/mmio_uart_pkg.sv | 23 ++
 rtl/mmio_uart_tx_byte_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are word indices taken from bus_address[3:2].
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Synchronous 8-bit FIFO with power-of-two depth; pushes while full and pops while
// empty are ignored, and the head entry is visible combinationally on pop_data.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; the count is one bit wider so full and empty differ.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: zero-wait bus decode, CTRL/overflow
// registers, a TX FIFO and the baud-timed serialiser FSM.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_hit,
    output logic        tx,
    output logic        tx_busy
);

    import mmio_uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    reg_sel;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_ctrl;
    logic          enable;
    logic          overflow;
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;

    logic          unused_bits;
    assign unused_bits = ^{bus_address[1:0], bus_write_data[31:8], bus_byte_enable[3:1]};

    assign bus_hit   = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = bus_address[3:2];
    assign wr_txdata = bus_hit && bus_write_enable && bus_byte_enable[0] && (reg_sel == REG_TXDATA);
    assign wr_status = bus_hit && bus_write_enable && bus_byte_enable[0] && (reg_sel == REG_STATUS);
    assign wr_ctrl   = bus_hit && bus_write_enable && bus_byte_enable[0] && (reg_sel == REG_CTRL);
    assign fifo_pop  = (state == ST_IDLE) && enable && !fifo_empty;
    assign tx_busy   = (state != ST_IDLE);

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (bus_write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Full is judged before the edge, so a same-cycle pop never rescues a dropped byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (wr_txdata && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_status && bus_write_data[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (wr_ctrl) begin
                enable <= bus_write_data[0];
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_EMPTY]    = fifo_empty;
        status_word[STAT_BUSY]     = tx_busy;
        status_word[STAT_OVERFLOW] = overflow;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        bus_read_data = '0;
        if (bus_hit && bus_read_enable) begin
            case (reg_sel)
                REG_STATUS: bus_read_data = status_word;
                REG_CTRL:   bus_read_data = {31'd0, enable};
                default:    bus_read_data = '0;
            endcase
        end
    end

    // Each non-idle state and each data bit lasts CLKS_PER_BIT cycles of baud_cnt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shifter  <= fifo_data;
                        baud_cnt <= BAUD_RELOAD;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        shifter  <= {1'b1, shifter[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shifter[0];
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-timeline model of the transmitter,
// directed scenarios with literal expectations, and a randomized bus phase.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hF000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        bus_hit;
    logic        tx;
    logic        tx_busy;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_data    (bus_read_data),
        .bus_hit          (bus_hit),
        .tx               (tx),
        .tx_busy          (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a queue of bytes plus the position inside the current 10-slot frame.
    logic [7:0] m_q[$];
    bit         m_overflow;
    bit         m_enable;
    bit         m_busy;
    int         m_pos;
    logic [7:0] m_byte;
    bit         m_pre_full;
    bit         m_pre_empty;
    bit         m_pre_enable;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_overflow = 1'b0;
            m_enable   = 1'b1;
            m_busy     = 1'b0;
            m_pos      = 0;
        end else begin
            m_pre_full   = (m_q.size() == DEPTH);
            m_pre_empty  = (m_q.size() == 0);
            m_pre_enable = m_enable;
            if (m_busy) begin
                m_pos++;
                if (m_pos == 10 * CPB) begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end
            end else if (m_pre_enable && !m_pre_empty) begin
                m_byte = m_q.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
            end
            if (bus_write_enable && bus_address[31:4] == BASE[31:4] && bus_byte_enable[0]) begin
                case (bus_address[3:2])
                    2'd0: begin
                        if (m_pre_full) m_overflow = 1'b1;
                        else m_q.push_back(bus_write_data[7:0]);
                    end
                    2'd1: if (bus_write_data[3]) m_overflow = 1'b0;
                    2'd2: m_enable = bus_write_data[0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic model_tx();
        int slot;
        if (!m_busy) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic re);
        int n;
        n = m_q.size();
        if (!re || addr[31:4] != BASE[31:4]) return 32'h0;
        if (addr[3:2] == 2'd1)
            return 32'(n * 16) + (m_overflow ? 32'd8 : 32'd0) + (m_busy ? 32'd4 : 32'd0)
                   + (n == 0 ? 32'd2 : 32'd0) + (n == DEPTH ? 32'd1 : 32'd0);
        if (addr[3:2] == 2'd2) return m_enable ? 32'd1 : 32'd0;
        return 32'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("tx", 32'(tx), 32'(model_tx()));
            checkOutput("tx_busy", 32'(tx_busy), 32'(m_busy));
        end
    end

    // One bus cycle: drive at the falling edge, check the combinational response, then clock it.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                                 input logic we, input logic re,
                                 output logic [31:0] rd, output logic hit);
        bus_address      = addr;
        bus_write_data   = data;
        bus_byte_enable  = be;
        bus_write_enable = we;
        bus_read_enable  = re;
        #1;
        rd  = bus_read_data;
        hit = bus_hit;
        checkOutput("bus_hit", 32'(bus_hit), 32'(addr[31:4] == BASE[31:4]));
        checkOutput("bus_read_data", bus_read_data, model_read(addr, re));
        @(posedge clock);
        @(negedge clock);
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
    endtask

    logic [31:0] rd;
    logic        hit;
    logic [9:0]  pat55;
    int          frames;
    int          gap;
    bit          prev_busy;
    int          low_count;
    logic [31:0] addr;
    logic [31:0] data;

    initial begin
        reset            = 1'b1;
        bus_address      = '0;
        bus_write_data   = '0;
        bus_byte_enable  = '0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(tx_busy), 32'd0);
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("reset_status", rd, 32'h2);
        applyStimulus(BASE + 32'h8, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("reset_ctrl", rd, 32'h1);

        $display("[TB] single 0x55 frame");
        pat55 = 10'b1010101010;
        applyStimulus(BASE, 32'h55, 4'h1, 1'b1, 1'b0, rd, hit);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clock);
            checkOutput("frame55_tx", 32'(tx), 32'(pat55[k / CPB]));
            checkOutput("frame55_busy", 32'(tx_busy), 32'd1);
        end
        @(negedge clock);
        checkOutput("frame55_end_busy", 32'(tx_busy), 32'd0);

        $display("[TB] overflow and burst");
        applyStimulus(BASE + 32'h8, 32'h0, 4'h1, 1'b1, 1'b0, rd, hit);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(BASE, $urandom, 4'h1, 1'b1, 1'b0, rd, hit);
        end
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("full_status", rd, 32'h89);
        applyStimulus(BASE + 32'h4, 32'h8, 4'b0010, 1'b1, 1'b0, rd, hit);
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("w1c_wrong_lane", rd, 32'h89);
        applyStimulus(BASE + 32'h4, 32'h8, 4'b0001, 1'b1, 1'b0, rd, hit);
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("w1c_clear", rd, 32'h81);
        applyStimulus(BASE + 32'h8, 32'h1, 4'h1, 1'b1, 1'b0, rd, hit);
        frames    = 0;
        gap       = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 8 * (10 * CPB + 1) + 20; c++) begin
            @(negedge clock);
            if (tx_busy && !prev_busy) begin
                frames++;
                if (frames > 1) checkOutput("frame_gap", gap, 1);
                gap = 0;
            end
            if (!tx_busy) gap++;
            prev_busy = tx_busy;
            if (frames == 8 && !tx_busy) break;
        end
        checkOutput("frame_count", frames, 8);
        checkOutput("burst_done_busy", 32'(tx_busy), 32'd0);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(BASE, 32'h00, 4'h1, 1'b1, 1'b0, rd, hit);
        end
        for (int c = 0; c < 20 && !tx_busy; c++) @(negedge clock);
        checkOutput("midframe_started", 32'(tx_busy), 32'd1);
        repeat (12) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_tx", 32'(tx), 32'd1);
        checkOutput("async_reset_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("post_reset_status", rd, 32'h2);
        applyStimulus(BASE + 32'h8, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("post_reset_ctrl", rd, 32'h1);
        low_count = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (tx !== 1'b1) low_count++;
        end
        checkOutput("post_reset_idle", low_count, 0);

        $display("[TB] window decode");
        applyStimulus(BASE + 32'h20, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("outside_hit", 32'(hit), 32'd0);
        checkOutput("outside_data", rd, 32'h0);
        applyStimulus(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, rd, hit);
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("reserved_status", rd, 32'h2);
        applyStimulus(BASE + 32'h8, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("reserved_ctrl", rd, 32'h1);
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b0, rd, hit);
        checkOutput("no_strobe_hit", 32'(hit), 32'd1);
        checkOutput("no_strobe_data", rd, 32'h0);

        $display("[TB] randomized bus traffic");
        for (int i = 0; i < 600; i++) begin
            addr = BASE + {26'd0, 2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h10 * $urandom_range(1, 4);
            data = $urandom;
            if (addr[3:2] == 2'd2) data[0] = ($urandom_range(0, 3) != 0);
            applyStimulus(addr, data, 4'($urandom), ($urandom_range(0, 2) == 0),
                          $urandom_range(0, 1) == 1, rd, hit);
        end
        applyStimulus(BASE + 32'h8, 32'h1, 4'h1, 1'b1, 1'b0, rd, hit);
        for (int c = 0; c < DEPTH * (10 * CPB + 2) + 20; c++) begin
            @(negedge clock);
            if (!tx_busy && m_q.size() == 0) break;
        end
        applyStimulus(BASE + 32'h4, 0, 4'h0, 1'b0, 1'b1, rd, hit);
        checkOutput("drained_empty", 32'(rd[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
